// File: rtl/tl_async_pkg.sv
// ---------------------------------------------------------------------------
// tl_async_pkg: A-channel entry layout and gray-code helpers shared by both crossing halves.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tl_async_pkg;

  localparam int A_OPCODE_W  = 3;
  localparam int A_PARAM_W   = 3;
  localparam int A_SIZE_W    = 2;
  localparam int A_SOURCE_W  = 1;
  localparam int A_ADDR_W    = 9;
  localparam int A_MASK_W    = 4;
  localparam int A_DATA_W    = 32;
  localparam int A_CORRUPT_W = 1;

  localparam int A_CORRUPT_LSB = 0;
  localparam int A_DATA_LSB    = 1;
  localparam int A_MASK_LSB    = 33;
  localparam int A_ADDR_LSB    = 37;
  localparam int A_SOURCE_LSB  = 46;
  localparam int A_SIZE_LSB    = 47;
  localparam int A_PARAM_LSB   = 49;
  localparam int A_OPCODE_LSB  = 52;
  localparam int A_ENTRY_W     = 55;

  // Widest pointer (DEPTH=8 -> AW+1 = 4); narrower pointers are zero-extended.
  localparam int PTR_MAX_W = 4;

  typedef struct packed {
    logic [A_OPCODE_W-1:0]  opcode;
    logic [A_PARAM_W-1:0]   param;
    logic [A_SIZE_W-1:0]    size;
    logic [A_SOURCE_W-1:0]  source;
    logic [A_ADDR_W-1:0]    address;
    logic [A_MASK_W-1:0]    mask;
    logic [A_DATA_W-1:0]    data;
    logic [A_CORRUPT_W-1:0] corrupt;
  } tl_a_entry_t;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tl_async_sync_vec.sv
// ---------------------------------------------------------------------------
// tl_async_sync_vec: STAGES-deep, WIDTH-wide asynchronously reset synchroniser chain.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tl_async_sync_vec #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [STAGES-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/tl_a_async_source.sv
// ---------------------------------------------------------------------------
// tl_a_async_source: enqueue half of the async TileLink A crossing; TL_ASYNC_SRC_SAFE_EN adds sink-reset safety.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tl_a_async_source
  import tl_async_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int SYNC  = 3
) (
  input  logic                           clock,
  input  logic                           reset_n,
  output logic                           enq_ready,
  input  logic                           enq_valid,
  input  logic [2:0]                     enq_opcode,
  input  logic [2:0]                     enq_param,
  input  logic [1:0]                     enq_size,
  input  logic                           enq_source,
  input  logic [8:0]                     enq_address,
  input  logic [3:0]                     enq_mask,
  input  logic [31:0]                    enq_data,
  input  logic                           enq_corrupt,
  output logic [DEPTH*A_ENTRY_W-1:0]     async_mem,
  output logic [$clog2(DEPTH):0]         async_widx,
  input  logic [$clog2(DEPTH):0]         async_ridx,
  output logic                           async_widx_valid,
  input  logic                           async_ridx_valid
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int IDXW   = (AW == 0) ? 1 : AW;
  localparam int MSB_LO = (AW == 0) ? 0 : AW - 1;
  // Full when the write pointer is exactly DEPTH ahead: gray equality with the top two bits inverted.
  localparam logic [PW-1:0] FULL_MASK = {PW{1'b1}} << MSB_LO;

  logic                 sink_ready;
  logic [PW-1:0]        ridx_s;
  logic [PW-1:0]        widx_bin_q, widx_bin_d;
  logic [PW-1:0]        widx_gray_q, widx_gray_d;
  logic                 ready_q, ready_d;
  logic [IDXW-1:0]      wr_idx;
  logic [PTR_MAX_W-1:0] gray_ext;
  logic [A_ENTRY_W-1:0] beat_vec;
  logic                 fire;
  logic                 full_next;
  tl_a_entry_t          mem_q [DEPTH];
  tl_a_entry_t          mem_d [DEPTH];

  tl_async_sync_vec #(
    .WIDTH  (PW),
    .STAGES (SYNC)
  ) u_ridx_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (async_ridx),
    .q       (ridx_s)
  );

`ifdef TL_ASYNC_SRC_SAFE_EN
  logic widx_valid_q, widx_valid_d;

  tl_async_sync_vec #(
    .WIDTH  (1),
    .STAGES (SYNC)
  ) u_valid_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (async_ridx_valid),
    .q       (sink_ready)
  );

  always_comb begin
    widx_valid_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      widx_valid_q <= 1'b0;
    end else begin
      widx_valid_q <= widx_valid_d;
    end
  end

  assign async_widx_valid = widx_valid_q;
`else
  logic unused_ridx_valid;
  assign unused_ridx_valid = async_ridx_valid;
  assign sink_ready        = 1'b1;
  assign async_widx_valid  = 1'b1;
`endif

  if (DEPTH == 1) begin : g_idx_single
    assign wr_idx = '0;
  end else begin : g_idx_multi
    assign wr_idx = widx_bin_q[IDXW-1:0];
  end

  always_comb begin
    beat_vec = '0;
    beat_vec[A_OPCODE_LSB  +: A_OPCODE_W]  = enq_opcode;
    beat_vec[A_PARAM_LSB   +: A_PARAM_W]   = enq_param;
    beat_vec[A_SIZE_LSB    +: A_SIZE_W]    = enq_size;
    beat_vec[A_SOURCE_LSB  +: A_SOURCE_W]  = enq_source;
    beat_vec[A_ADDR_LSB    +: A_ADDR_W]    = enq_address;
    beat_vec[A_MASK_LSB    +: A_MASK_W]    = enq_mask;
    beat_vec[A_DATA_LSB    +: A_DATA_W]    = enq_data;
    beat_vec[A_CORRUPT_LSB +: A_CORRUPT_W] = enq_corrupt;

    fire = enq_valid & ready_q;

    // A beat accepted as the sink drops still lands; the pointer clears on the following cycle.
    widx_bin_d = widx_bin_q;
    if (fire) begin
      widx_bin_d = widx_bin_q + PW'(1);
    end else if (!sink_ready) begin
      widx_bin_d = '0;
    end

    gray_ext    = bin2gray(PTR_MAX_W'(widx_bin_d));
    widx_gray_d = gray_ext[PW-1:0];
    full_next   = (gray_ext == PTR_MAX_W'(ridx_s ^ FULL_MASK));
    ready_d     = sink_ready & ~full_next;

    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (fire && (wr_idx == IDXW'(i))) begin
        mem_d[i] = tl_a_entry_t'(beat_vec);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      widx_bin_q  <= '0;
      widx_gray_q <= '0;
      ready_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      widx_bin_q  <= widx_bin_d;
      widx_gray_q <= widx_gray_d;
      ready_q     <= ready_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_mem_out
    assign async_mem[g*A_ENTRY_W +: A_ENTRY_W] = mem_q[g];
  end

  assign enq_ready  = ready_q;
  assign async_widx = widx_gray_q;

endmodule

`default_nettype wire
